oam_dma_engine: RTL

//   OAM DMA controller behind the FF46 register. A CPU write of byte XX to 0xFF46

---
 rtl/oam_dma_engine_if.sv | 22 ++
 rtl/oam_dma_engine.sv | 139 +++++++++++++
 2 files changed

// File: rtl/oam_dma_engine_if.sv
// Byte-wide memory-style port shared between mmu_m and the OAM DMA engine.
// The master drives address/data/strobe; the slave returns read data.
interface mem_if;
  logic [15:0] addr_select;
  logic [7:0]  write_value;
  logic        write_enable;
  logic [7:0]  read_out;

  modport master (
    output addr_select,
    output write_value,
    output write_enable,
    input  read_out
  );

  modport slave (
    input  addr_select,
    input  write_value,
    input  write_enable,
    output read_out
  );
endinterface

// File: rtl/oam_dma_engine.sv
// OAM DMA engine behind FF46: copies NUM_BYTES from {src,00} to FE00.
// Bus outputs are registered and computed from next-state values.
module oam_dma_engine #(
  parameter int CYCLES_PER_BYTE = 4,
  parameter int READ_LATENCY    = 1,
  parameter int START_DELAY     = 4,
  parameter int NUM_BYTES       = 160
) (
  input  logic  clk,
  input  logic  rst,
  mem_if.slave  mmio_dma_if,
  mem_if.master dma_req,
  output logic  active
);
  localparam int PW = (CYCLES_PER_BYTE > 1) ?
                      $clog2(CYCLES_PER_BYTE) : 1;
  localparam int DW = (START_DELAY > 1) ?
                      $clog2(START_DELAY) : 1;

  localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
  localparam logic [PW-1:0] PH_CAP   = PW'(READ_LATENCY);
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DELAY - 1);
  localparam logic [7:0]    CNT_LAST = 8'(NUM_BYTES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_XFER  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [7:0]    src_q, src_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [7:0]    data_q, data_d;
  logic          wen_prev_q;
  logic [15:0]   addr_q, addr_d;
  logic [7:0]    wv_q, wv_d;
  logic          we_q, we_d;
  logic          wr_hit;
  logic [7:0]    base_hi;

  assign wr_hit = (mmio_dma_if.addr_select == 16'hFF46) &&
                  mmio_dma_if.write_enable && !wen_prev_q;

  assign mmio_dma_if.read_out =
    (mmio_dma_if.addr_select == 16'hFF46) ? src_q : 8'hFF;

  // Echo RAM E000-FDFF mirrors C000-DDFF.
  assign base_hi = (src_d >= 8'hE0) ? src_d - 8'h20 : src_d;

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    dly_d   = dly_q;
    data_d  = data_q;
    if (state_q == S_XFER && phase_q == PH_CAP)
      data_d = dma_req.read_out;
    if (wr_hit) begin
      src_d   = mmio_dma_if.write_value;
      cnt_d   = 8'd0;
      phase_d = '0;
      dly_d   = '0;
      state_d = S_START;
    end else begin
      unique case (1'b1)
        (state_q == S_START): begin
          if (dly_q == DLY_LAST) begin
            state_d = S_XFER;
            phase_d = '0;
          end else begin
            dly_d = dly_q + DW'(1);
          end
        end
        (state_q == S_XFER): begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            if (cnt_q == CNT_LAST) begin
              state_d = S_IDLE;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_d = 16'hFFFF;
    we_d   = 1'b0;
    wv_d   = 8'h00;
    if (state_d == S_XFER) begin
      if (phase_d == PH_LAST) begin
        addr_d = 16'hFE00 + {8'h00, cnt_d};
        we_d   = 1'b1;
        wv_d   = data_d;
      end else begin
        addr_d = {base_hi, cnt_d};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      src_q      <= 8'hFF;
      cnt_q      <= 8'd0;
      phase_q    <= '0;
      dly_q      <= '0;
      data_q     <= 8'h00;
      wen_prev_q <= 1'b0;
      addr_q     <= 16'hFFFF;
      wv_q       <= 8'h00;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      cnt_q      <= cnt_d;
      phase_q    <= phase_d;
      dly_q      <= dly_d;
      data_q     <= data_d;
      wen_prev_q <= mmio_dma_if.write_enable;
      addr_q     <= addr_d;
      wv_q       <= wv_d;
      we_q       <= we_d;
    end
  end

  assign dma_req.addr_select  = addr_q;
  assign dma_req.write_value  = wv_q;
  assign dma_req.write_enable = we_q;
  assign active               = (state_q != S_IDLE);
endmodule
